// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps GUT inputs in ascending order, HOLD cycles each, checks y_in against EXP_TT.
// Done after 2**N_IN*HOLD cycles; define GATE_SWEEP_FAIL_CAPTURE_EN to add first-failure capture outputs.
module gate_sweep_ctrl #(
  parameter int                     N_IN   = 2,
  parameter int                     HOLD   = 2,
  parameter logic [(1<<N_IN)-1:0]   EXP_TT = 4'b1110,
  parameter int                     CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec
`endif
);

  localparam int            HW        = $clog2(HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [HW-1:0]    hcnt;
  logic             sample;
  logic             mismatch;
  logic             accept;
  logic [CNT_W-1:0] err_nxt;

  assign sample   = (state == S_APPLY) && (hcnt == HOLD_LAST);
  assign mismatch = sample && (y_in != EXP_TT[vec]);
  assign accept   = start && (state != S_APPLY);

  // Saturating count including this cycle's mismatch, so pass can be taken on the final sample edge.
  always_comb begin
    err_nxt = err_cnt;
    if (mismatch && (err_cnt != {CNT_W{1'b1}}))
      err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      vec     <= '0;
      hcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_APPLY;
            vec     <= '0;
            hcnt    <= '0;
            err_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        S_APPLY: begin
          err_cnt <= err_nxt;
          if (!sample) begin
            hcnt <= hcnt + 1'b1;
          end else if (vec == {N_IN{1'b1}}) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            vec  <= vec + 1'b1;
            hcnt <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (accept) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= vec;
    end
  end
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: default OR sweep, stuck faults, start handling, async reset, HOLD=1 AND.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] vec;
  logic       y_in;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  int         mode = 0;   // 0: OR model, 1: stuck at 0, 2: stuck at 1

  logic       start2 = 1'b0;
  logic [1:0] vec2;
  logic       y2;
  logic       busy2, done2, pass2;
  logic [7:0] err2;

`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
  logic       fail_valid, fail_valid2;
  logic [1:0] fail_vec, fail_vec2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    y_in = vec[0] | vec[1];
    if (mode == 1) y_in = 1'b0;
    else if (mode == 2) y_in = 1'b1;
  end
  assign y2 = vec2[0] & vec2[1];

  gate_sweep_ctrl #(.N_IN(2), .HOLD(2), .EXP_TT(4'b1110), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    , .fail_valid(fail_valid), .fail_vec(fail_vec)
`endif
  );

  gate_sweep_ctrl #(.N_IN(2), .HOLD(1), .EXP_TT(4'b1000), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .vec(vec2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    , .fail_valid(fail_valid2), .fail_vec(fail_vec2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Pulses start, walks the 8 cycles of a default sweep checking vec/busy, then checks the DONE outputs.
  // poke re-asserts start mid-sweep, which must have no effect.
  task automatic sweep(input string name, input int exp_err, input bit exp_pass,
                       input bit poke, input bit exp_fv, input logic [1:0] exp_fvec);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({name, "_err_clear"}, err_cnt, 0);
    chk({name, "_done_clear"}, done, 0);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("%s_vec%0d", name, n), vec, n / 2);
      chk($sformatf("%s_busy%0d", name, n), busy, 1);
      if (poke && n == 3) start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_pass"}, pass, exp_pass);
    chk({name, "_err"}, err_cnt, exp_err);
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    chk({name, "_fail_valid"}, fail_valid, exp_fv);
    if (exp_fv) chk({name, "_fail_vec"}, fail_vec, exp_fvec);
`endif
    repeat (3) @(negedge clk);
    chk({name, "_done_hold"}, done, 1);
    chk({name, "_vec_hold"}, vec, 3);
  endtask

  initial begin
    #2;
    chk("rst_vec", vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: correct OR model
    mode = 0;
    sweep("or_ok", 0, 1'b1, 1'b0, 1'b0, 2'b00);

    // 2: stuck at 0 -> vectors 1,2,3 mismatch
    mode = 1;
    sweep("stuck0", 3, 1'b0, 1'b0, 1'b1, 2'b01);

    // 4b: start from DONE after a failing run clears the count
    mode = 0;
    sweep("restart", 0, 1'b1, 1'b0, 1'b0, 2'b00);

    // 3: stuck at 1 -> only vector 0 mismatches
    mode = 2;
    sweep("stuck1", 1, 1'b0, 1'b0, 1'b1, 2'b00);

    // 4a: start during busy is ignored
    mode = 0;
    sweep("poke", 0, 1'b1, 1'b1, 1'b0, 2'b00);

    // 5: asynchronous reset while vec = 2
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_vec2", vec, 2);
    #1 rst = 1'b1;
    #1;
    chk("arst_vec", vec, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_err", err_cnt, 0);
    @(negedge clk) rst = 1'b0;
    sweep("post_rst", 0, 1'b1, 1'b0, 1'b0, 2'b00);

    // 6: HOLD=1 with AND truth table
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("and_vec%0d", n), vec2, n);
      chk($sformatf("and_busy%0d", n), busy2, 1);
      @(negedge clk);
    end
    chk("and_done", done2, 1);
    chk("and_busy_end", busy2, 0);
    chk("and_pass", pass2, 1);
    chk("and_err", err2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-test sequencer for a small combinational gate under test (GUT). On a start request it sweeps the GUT inputs through every input combination in ascending binary order, holds each vector for a programmable number of cycles, samples the GUT output and checks it against a parameterised truth table. It reports busy, done, pass/fail and an error count. It sits beside the gate primitives (OR, AND, XOR, …) as the block that sequences and checks them in hardware instead of from a bench `initial` block.

## Interface
Parameters:
- `N_IN`, 2: number of GUT inputs; range 1–4.
- `HOLD`, 2: cycles each vector is held; must be ≥1.
- `EXP_TT`, `4'b1110`: expected truth table, width 2**N_IN. Bit k is the expected output for input vector k. The default is 2-input OR.
- `CNT_W`, 8: error counter width.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`, in, 1: clock; all state updates on the rising edge.
  - `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: run request, sampled on the rising edge.
- `vec`, out, N_IN: drives the GUT inputs; bit 0 is the LSB input (`a` for a 2-input gate, with `b` on bit 1).
- `y_in`, in, 1: GUT output.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: sweep complete; a level, held until the next accepted start.
- `pass`, out, 1: valid while `done`; 1 if and only if `err_cnt == 0`.
- `err_cnt`, out, CNT_W: mismatch count for the current or last run.

## Operation
States: IDLE, APPLY, DONE. There is a single sweep counter `vec` and a hold counter `hcnt` of width clog2(HOLD)+1.

- **Reset:** reset forces the following, regardless of the clock:
  - state = IDLE
  - `vec` = 0, `hcnt` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0
  - optional fail outputs = 0
- **IDLE or DONE, `start` = 1:** go to APPLY. Set `vec` = 0, `hcnt` = 0, `err_cnt` = 0, `busy` = 1, `done` = 0, `pass` = 0.
- **APPLY, `hcnt` < HOLD-1:** `hcnt` increments.
- **APPLY, `hcnt` == HOLD-1 (sample cycle):**
  - Compare `y_in` against `EXP_TT[vec]`. On a mismatch, `err_cnt` increments, saturating at 2**CNT_W-1.
  - If `vec` is all ones: go to DONE with `busy` = 0, `done` = 1, and `pass` = (final `err_cnt` == 0). The final count includes the mismatch from this cycle.
  - Otherwise: `vec` increments and `hcnt` = 0.
- **`start` while in APPLY:** ignored; no restart and no effect on counters.
- **DONE:** `vec` holds its last value (all ones); the outputs hold until the next `start`.
- **`vec` wrap:** `vec` never wraps. The exit from APPLY is taken on the all-ones vector.
- **Comparison path:** purely registered. `y_in` is treated as a combinational function of `vec`, with at least HOLD-1 cycles of settling before sampling.

## Timing
- `start` is sampled at edge E0. `busy` = 1 and `vec` = 0 are visible after E0.
- Vector k is driven from E0 + k·HOLD to E0 + (k+1)·HOLD. `y_in` is sampled at edge E0 + (k+1)·HOLD.
- `done` = 1 and `busy` = 0 appear after edge E0 + 2**N_IN · HOLD. For the defaults this is 8 cycles after the start edge.
- `err_cnt` updates one edge after each sample cycle. `pass` is valid in the same cycle `done` rises.
- With HOLD = 1, a new vector is applied every cycle and the output is sampled every cycle.

## Configuration
- `GATE_SWEEP_FAIL_CAPTURE_EN`:
  - **Defined:** adds outputs `fail_valid` (out, 1) and `fail_vec` (out, N_IN). On the first mismatch of a run they capture that cycle's `vec` and set `fail_valid` = 1. Later mismatches do not overwrite them. Both clear on an accepted `start` and on `rst`.
  - **Undefined:** the ports and their logic are absent, and the remaining behaviour is identical.

## Test plan
1. **Correct OR model, defaults:** pulse `start` → `vec` follows 0,0,1,1,2,2,3,3 → `done` = 1 after 8 cycles with `pass` = 1 and `err_cnt` = 0.
2. **`y_in` stuck at 0:**
   - `err_cnt` = 3 and `pass` = 0.
   - With the macro defined: `fail_valid` = 1 and `fail_vec` = 2'b01.
3. **`y_in` stuck at 1:** `err_cnt` = 1 and `pass` = 0; with the macro defined, `fail_vec` = 2'b00.
4. **Start handling:** pulse `start` again while `busy` → the sequence and the 8-cycle length are unchanged. Then pulse `start` in DONE after a failing run → `err_cnt` clears to 0 and a full fresh sweep runs.
5. **Reset mid-run:** assert `rst` during `vec` = 2'b10 → all outputs go to 0 immediately, without waiting for a clock edge. After release, a `start` runs a complete sweep from `vec` = 0.
6. **HOLD = 1, EXP_TT = 4'b1000 with an AND model:** `vec` = 0,1,2,3 on consecutive cycles → `done` after 4 cycles with `pass` = 1.
